conv_pe_array_kxk: RTL and testbench

- Parametrised successor of the fixed 3x3/5x5 PE array; performs a valid-mode 2-D convolution of one HxW ifmap tile with one KxK filter.
- Emits OH x OW outputs (OH=H-K+1, OW=W-K+1) as a raster-order valid/ready stream.
- Adds start/busy/done control, output backpressure and signed full-precision accumulation.
- Sits between the tile loader (flat ifmap/filter buses) and the psum accumulator.

---
 rtl/conv_pe_array_kxk_pkg.sv | 21 ++
 rtl/conv_pe_array_kxk_if.sv | 22 ++
 rtl/conv_pe_array_kxk_window_mac.sv | 55 +++++
 rtl/conv_pe_array_kxk.sv | 141 ++++++++++++++
 tb/tb_conv_pe_array_kxk.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pe_array_kxk_pkg.sv
// Shared FSM state type and width helpers for the KxK convolution PE array.
package conv_pe_array_kxk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } state_t;

    function automatic int idx_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Full-precision width for a sum of k*k signed data_w x data_w products.
    function automatic int acc_width(input int data_w, input int k);
        return 2 * data_w + $clog2(k * k) + 1;
    endfunction

endpackage

// File: rtl/conv_pe_array_kxk_if.sv
// Raster-order result stream (valid/ready) from the PE array to the psum accumulator.
interface conv_pe_array_kxk_if #(
    parameter int ACC_W = 37,
    parameter int ROW_W = 3,
    parameter int COL_W = 3
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic        [ROW_W-1:0] out_row;
    logic        [COL_W-1:0] out_col;

    modport master (
        output out_valid, out_data, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col,
        output out_ready
    );
endinterface

// File: rtl/conv_pe_array_kxk_window_mac.sv
// KxK multiplier bank (stage 1) and registered adder tree (stage 2) for one window.
// Optional macro CONV_RELU_EN clamps negative sums to zero in stage 2.
module conv_window_mac #(
    parameter int DATA_W = 16,
    parameter int K      = 3,
    parameter int ACC_W  = 2 * DATA_W + $clog2(K * K) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_prod,
    input  logic                      load_sum,
    input  logic [K*K*DATA_W-1:0]     window,
    input  logic [K*K*DATA_W-1:0]     filter,
    output logic signed [ACC_W-1:0]   sum
);
    logic [K*K-1:0][2*DATA_W-1:0] prod;
    logic [K*K-1:0][2*DATA_W-1:0] prod_q;
    logic signed [ACC_W-1:0]      part [K*K+1];
    logic signed [ACC_W-1:0]      sum_d;

    assign part[0] = '0;

    for (genvar g = 0; g < K * K; g++) begin : g_tap
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
        assign a = window[g*DATA_W +: DATA_W];
        assign b = filter[g*DATA_W +: DATA_W];
        assign prod[g] = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        assign part[g+1] = part[g] + ACC_W'($signed(prod_q[g]));
    end

    always_comb begin
        sum_d = part[K*K];
`ifdef CONV_RELU_EN
        if (sum_d[ACC_W-1]) begin
            sum_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            sum    <= '0;
        end else begin
            if (load_prod) begin
                prod_q <= prod;
            end
            if (load_sum) begin
                sum <= sum_d;
            end
        end
    end

endmodule

// File: rtl/conv_pe_array_kxk.sv
// Valid-mode 2-D convolution of an HxW ifmap tile with a KxK filter, streamed
// out in raster order with start/busy/done control and output backpressure.
module conv_pe_array_kxk
    import conv_pe_array_kxk_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int K      = 3,
    parameter int H      = 5,
    parameter int W      = 5,
    parameter int ACC_W  = acc_width(DATA_W, K)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [H*W*DATA_W-1:0] ifmap_in_flat,
    input  logic [K*K*DATA_W-1:0] filter_in_flat,
    output logic                  busy,
    output logic                  done,
    conv_pe_array_kxk_if.master   out_if
);
    localparam int OH    = H - K + 1;
    localparam int OW    = W - K + 1;
    localparam int ROW_W = idx_width(OH);
    localparam int COL_W = idx_width(OW);

    state_t                  state;
    logic [H*W*DATA_W-1:0]   ifmap_q;
    logic [K*K*DATA_W-1:0]   filter_q;
    logic [ROW_W-1:0]        wr;
    logic [COL_W-1:0]        wc;
    logic [ROW_W-1:0]        r1;
    logic [COL_W-1:0]        c1;
    logic                    v1;
    logic                    adv;
    logic                    issue;
    logic [K*K*DATA_W-1:0]   window;
    logic signed [ACC_W-1:0] sum;

    // A held result freezes every stage, including the window counters.
    assign adv   = !(out_if.out_valid && !out_if.out_ready);
    assign issue = (state == ST_RUN) && adv;

    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            assign window[(i*K+j)*DATA_W +: DATA_W] =
                DATA_W'(ifmap_q >> (((int'(wr) + i) * W + int'(wc) + j) * DATA_W));
        end
    end

    conv_window_mac #(
        .DATA_W (DATA_W),
        .K      (K),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_prod (issue),
        .load_sum  (adv && v1),
        .window    (window),
        .filter    (filter_q),
        .sum       (sum)
    );

    assign out_if.out_data = sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            ifmap_q          <= '0;
            filter_q         <= '0;
            wr               <= '0;
            wc               <= '0;
            v1               <= 1'b0;
            r1               <= '0;
            c1               <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_row   <= '0;
            out_if.out_col   <= '0;
        end else begin
            done <= 1'b0;
            if (adv) begin
                v1               <= issue;
                out_if.out_valid <= v1;
                if (issue) begin
                    r1 <= wr;
                    c1 <= wc;
                end
                if (v1) begin
                    out_if.out_row <= r1;
                    out_if.out_col <= c1;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ifmap_q  <= ifmap_in_flat;
                        filter_q <= filter_in_flat;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    wr    <= '0;
                    wc    <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (adv) begin
                        if (wc == COL_W'(OW - 1)) begin
                            wc <= '0;
                            if (wr == ROW_W'(OH - 1)) begin
                                state <= ST_DRAIN;
                            end else begin
                                wr <= wr + 1'b1;
                            end
                        end else begin
                            wc <= wc + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Last result is the one accepted with stage 1 already empty.
                    if (out_if.out_valid && out_if.out_ready && !v1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pe_array_kxk.sv
// Directed self-checking bench for conv_pe_array_kxk at K=3, H=W=5, DATA_W=16.
// Expected negative-sum results follow CONV_RELU_EN when it is defined.
module tb_conv_pe_array_kxk;
    logic         clk;
    logic         rst_n;
    logic         start;
    logic [399:0] ifmap_in_flat;
    logic [143:0] filter_in_flat;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int exp_data [9];
    int cyc;

    conv_pe_array_kxk_if #(.ACC_W(37), .ROW_W(3), .COL_W(3)) bus ();

    conv_pe_array_kxk #(
        .DATA_W (16),
        .K      (3),
        .H      (5),
        .W      (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .ifmap_in_flat  (ifmap_in_flat),
        .filter_in_flat (filter_in_flat),
        .busy           (busy),
        .done           (done),
        .out_if         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [399:0] ifm_ramp();
        logic [399:0] f = '0;
        for (int unsigned e = 0; e < 25; e++) begin
            f |= 400'(16'(e)) << (e * 16);
        end
        return f;
    endfunction

    function automatic logic [399:0] ifm_const(input logic [15:0] v);
        logic [399:0] f = '0;
        for (int unsigned e = 0; e < 25; e++) begin
            f |= 400'(v) << (e * 16);
        end
        return f;
    endfunction

    function automatic logic [143:0] flt_const(input logic [15:0] v);
        logic [143:0] f = '0;
        for (int unsigned e = 0; e < 9; e++) begin
            f |= 144'(v) << (e * 16);
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input logic [399:0] ifm, input logic [143:0] flt);
        ifmap_in_flat  = ifm;
        filter_in_flat = flt;
        start          = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic collect(input string tag, input int n, input logic [3:0] rdy_pat,
                           input bit exp_done, output int cycles);
        int     got   = 0;
        int     c     = 0;
        int     early = 0;
        bit     stalled = 0;
        longint hd = 0;
        int     hr = 0;
        int     hc = 0;
        while (got < n && c < 300) begin
            bus.out_ready = rdy_pat[2'(c)];
            if (stalled) begin
                check({tag, "_hold_valid"}, bus.out_valid, 1);
                check({tag, "_hold_data"}, bus.out_data, hd);
                check({tag, "_hold_row"}, bus.out_row, hr);
                check({tag, "_hold_col"}, bus.out_col, hc);
                stalled = 0;
            end
            if (done) early++;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    check({tag, "_data"}, bus.out_data, exp_data[got]);
                    check({tag, "_row"}, bus.out_row, got / 3);
                    check({tag, "_col"}, bus.out_col, got % 3);
                    got++;
                end else begin
                    stalled = 1;
                    hd = bus.out_data;
                    hr = int'(bus.out_row);
                    hc = int'(bus.out_col);
                end
            end
            tick();
            c++;
        end
        cycles = c;
        check({tag, "_count"}, got, n);
        check({tag, "_early_done"}, early, 0);
        if (exp_done) begin
            check({tag, "_done"}, done, 1);
            check({tag, "_busy_fin"}, busy, 0);
            check({tag, "_valid_fin"}, bus.out_valid, 0);
            bus.out_ready = 1'b0;
            tick();
            check({tag, "_done_once"}, done, 0);
            check({tag, "_busy_idle"}, busy, 0);
            check({tag, "_no_extra"}, bus.out_valid, 0);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        bus.out_ready  = 1'b0;
        ifmap_in_flat  = '0;
        filter_in_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_done", done, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_row", bus.out_row, 0);
        check("rst_col", bus.out_col, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Centre tap on a ramp ifmap picks out the interior elements.
        exp_data = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
        start_tile(ifm_ramp(), 144'(16'd1) << (4 * 16));
        collect("centre", 9, 4'b1111, 1, cyc);

        // All-ones filter on constant 2: latency and one-per-cycle rate.
        for (int i = 0; i < 9; i++) exp_data[i] = 18;
        bus.out_ready = 1'b1;
        start_tile(ifm_const(16'd2), flt_const(16'd1));
        tick();
        tick();
        check("lat_pre", bus.out_valid, 0);
        tick();
        check("lat_first", bus.out_valid, 1);
        collect("ones", 9, 4'b1111, 1, cyc);
        check("ones_rate", cyc, 9);

        // Backpressure with ready pattern 1,0,0,1.
        start_tile(ifm_const(16'd2), flt_const(16'd1));
        collect("stall", 9, 4'b1001, 1, cyc);

        // Negative sums.
`ifdef CONV_RELU_EN
        for (int i = 0; i < 9; i++) exp_data[i] = 0;
`else
        for (int i = 0; i < 9; i++) exp_data[i] = -27;
`endif
        start_tile(ifm_const(16'd3), flt_const(16'hFFFF));
        collect("neg", 9, 4'b1111, 1, cyc);

        // Second start during RUN with new bus data must be ignored.
        exp_data = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
        bus.out_ready = 1'b1;
        start_tile(ifm_ramp(), 144'(16'd1) << (4 * 16));
        tick();
        ifmap_in_flat  = ifm_const(16'd7);
        filter_in_flat = flt_const(16'd5);
        start          = 1'b1;
        tick();
        start = 1'b0;
        collect("restart", 9, 4'b1111, 1, cyc);

        // Abort with reset while the 4th output is presented.
        for (int i = 0; i < 9; i++) exp_data[i] = 18;
        start_tile(ifm_const(16'd2), flt_const(16'd1));
        collect("pre_rst", 3, 4'b1111, 0, cyc);
        check("rst_4th_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", bus.out_valid, 0);
        check("abort_done", done, 0);
        check("abort_data", bus.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("abort_idle_done", done, 0);
        exp_data = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
        start_tile(ifm_ramp(), 144'(16'd1) << (4 * 16));
        collect("post_rst", 9, 4'b1111, 1, cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
